// File: rtl/draw_pkg.sv
// Shared constants for the 160x120, 3-bit-colour drawing path.
package draw_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StDone
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    int unsigned j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/rect_draw_arbiter.sv
// Round-robin arbiter that scans one granted filled rectangle per request onto the
// vga_adapter pixel port, one pixel per clock.
module rect_draw_arbiter
    import draw_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned X_W  = 8,
    parameter int unsigned Y_W  = 7,
    parameter int unsigned D_W  = 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*X_W-1:0] req_x,
    input  logic [NREQ*Y_W-1:0] req_y,
    input  logic [NREQ*D_W-1:0] req_w,
    input  logic [NREQ*D_W-1:0] req_h,
    input  logic [NREQ*3-1:0]   req_colour,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic                busy,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [2:0]          colour,
    output logic                plot
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]  gidx_q, gidx_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [X_W-1:0]    x0_q, x0_d;
    logic [Y_W-1:0]    y0_q, y0_d;
    logic [D_W-1:0]    w_q, w_d;
    logic [D_W-1:0]    h_q, h_d;
    logic [D_W-1:0]    cx_q, cx_d;
    logic [D_W-1:0]    cy_q, cy_d;
    logic [2:0]        c0_q, c0_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [X_W-1:0]    sel_x;
    logic [Y_W-1:0]    sel_y;
    logic [D_W-1:0]    sel_w;
    logic [D_W-1:0]    sel_h;
    logic [2:0]        sel_c;
    logic              row_end;
    logic              last_pix;
    logic [X_W:0]      x_sum;
    logic [Y_W:0]      y_sum;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_w = '0;
        sel_h = '0;
        sel_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_idx == PTR_W'(i)) begin
                sel_x = req_x[i*X_W +: X_W];
                sel_y = req_y[i*Y_W +: Y_W];
                sel_w = req_w[i*D_W +: D_W];
                sel_h = req_h[i*D_W +: D_W];
                sel_c = req_colour[i*3 +: 3];
            end
        end
    end

    assign row_end  = (cx_q == w_q - D_W'(1));
    assign last_pix = row_end && (cy_q == h_q - D_W'(1));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero-area grant keeps grant_q set for its first DONE cycle, so DONE
    // lingers one cycle and grant/done never overlap.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = (sel_w == '0 || sel_h == '0) ? StDone : StDraw;
                end
            end
            StDraw: begin
                if (last_pix) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (grant_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            c0_q    <= '0;
        end else begin
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            c0_q    <= c0_d;
        end
    end

    always_comb begin
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        c0_d    = c0_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    x0_d    = sel_x;
                    y0_d    = sel_y;
                    w_d     = sel_w;
                    h_d     = sel_h;
                    c0_d    = sel_c;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            StDraw: begin
                if (row_end) begin
                    cx_d = '0;
                    cy_d = cy_q + D_W'(1);
                end else begin
                    cx_d = cx_q + D_W'(1);
                end
                if (last_pix) begin
                    grant_d = '0;
                end
            end
            StDone: begin
                grant_d = '0;
                if (grant_q == '0) begin
                    ptr_d = (gidx_q == PTR_W'(NREQ - 1)) ? '0 : gidx_q + PTR_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        x_sum  = (X_W+1)'(x0_q) + (X_W+1)'(cx_q);
        y_sum  = (Y_W+1)'(y0_q) + (Y_W+1)'(cy_q);
        vga_x  = x_sum[X_W-1:0];
        vga_y  = y_sum[Y_W-1:0];
        colour = c0_q;
        plot   = (state_q == StDraw) && (x_sum < (X_W+1)'(SCREEN_W))
                 && (y_sum < (Y_W+1)'(SCREEN_H));
        grant  = grant_q;
        busy   = (state_q != StIdle);
        done   = '0;
        if (state_q == StDone && grant_q == '0) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gidx_q == PTR_W'(i)) begin
                    done[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// Directed bench for rect_draw_arbiter with a pixel scoreboard fed at request time.
module tb_rect_draw_arbiter;
    import draw_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  req;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [23:0] req_w;
    logic [23:0] req_h;
    logic [8:0]  req_colour;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic        busy;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  colour;
    logic        plot;

    int errors = 0;
    int checks = 0;
    int plot_cnt = 0;
    bit mon_en = 1'b0;
    logic [17:0] exp_q[$];

    rect_draw_arbiter u_dut (
        .clock      (clk),
        .resetn     (resetn),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .colour     (colour),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected pixels in raster order, clipped to the visible screen.
    task automatic push_rect(input int x, input int y, input int w, input int h, input int c);
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                if (x + k < 160 && y + r < 120) begin
                    exp_q.push_back({8'(x + k), 7'(y + r), 3'(c)});
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("grant_done_excl", 32'((|grant) && (|done)), 32'd0);
            if (plot) begin
                plot_cnt++;
                chk("plot_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("pixel", {14'd0, vga_x, vga_y, colour}, {14'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Post one rectangle on requester i; optionally move its x after grant.
    task automatic req_one(input int i, input int x, input int y, input int w, input int h,
                           input int c, input int chg_x);
        int n;
        int npix;
        wait_idle();
        plot_cnt = 0;
        req_x[i*8 +: 8]      = 8'(x);
        req_y[i*7 +: 7]      = 7'(y);
        req_w[i*8 +: 8]      = 8'(w);
        req_h[i*8 +: 8]      = 8'(h);
        req_colour[i*3 +: 3] = 3'(c);
        req[i]               = 1'b1;
        push_rect(x, y, w, h, c);
        npix = 0;
        for (int r = 0; r < h; r++)
            for (int k = 0; k < w; k++)
                if (x + k < 160 && y + r < 120) npix++;
        @(posedge clk);
        @(negedge clk);
        chk("grant", 32'(grant), 32'(1 << i));
        req[i] = 1'b0;
        if (chg_x >= 0) req_x[i*8 +: 8] = 8'(chg_x);
        n = 1;
        while (done[i] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_latency", 32'(n), 32'((w * h == 0) ? 2 : w * h + 1));
        chk("done_onehot", 32'(done), 32'(1 << i));
        chk("grant_at_done", 32'(grant), 32'd0);
        chk("plot_count", 32'(plot_cnt), 32'(npix));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        resetn     = 1'b0;
        req        = '0;
        req_x      = '0;
        req_y      = '0;
        req_w      = '0;
        req_h      = '0;
        req_colour = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pixel", {14'd0, vga_x, vga_y, colour}, 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        resetn = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Fairness: all three requesters held with 1x1 rectangles.
        for (int i = 0; i < 3; i++) begin
            req_x[i*8 +: 8]      = 8'(i * 10);
            req_y[i*7 +: 7]      = 7'(i * 10);
            req_w[i*8 +: 8]      = 8'd1;
            req_h[i*8 +: 8]      = 8'd1;
            req_colour[i*3 +: 3] = 3'(i + 1);
        end
        for (int g = 0; g < 6; g++) push_rect((g % 3) * 10, (g % 3) * 10, 1, 1, (g % 3) + 1);
        req = 3'b111;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            while (grant === 3'b000 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("fair_grant", 32'(grant), 32'(1 << (g % 3)));
            n = 0;
            while (done === 3'b000 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("fair_done", 32'(done), 32'(1 << (g % 3)));
        end
        req = '0;
        chk("fair_queue", 32'(exp_q.size()), 32'd0);

        req_one(0, 10, 20, 3, 2, RED, -1);
        req_one(1, 30, 40, 0, 5, BLUE, -1);
        req_one(0, 158, 119, 4, 2, WHITE, -1);
        req_one(2, 10, 30, 4, 2, CYAN, 50);

        // Reset while drawing a 10x10 rectangle, asserted on pixel 37.
        wait_idle();
        req_x[7:0]      = 8'd0;
        req_y[6:0]      = 7'd0;
        req_w[7:0]      = 8'd10;
        req_h[7:0]      = 8'd10;
        req_colour[2:0] = MAGENTA;
        for (int p = 0; p < 38; p++) exp_q.push_back({8'(p % 10), 7'(p / 10), MAGENTA});
        req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        repeat (37) @(negedge clk);
        chk("pix37_x", 32'(vga_x), 32'd7);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pixel", {14'd0, vga_x, vga_y, colour}, 32'd0);
        chk("mid_rst_plot", 32'(plot), 32'd0);
        chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        resetn = 1'b1;
        @(negedge clk);
        req_one(2, 5, 5, 2, 2, GREEN, -1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rect_draw_arbiter.md
# rect_draw_arbiter

Shares the single `vga_adapter` pixel-write port among several rectangle-drawing requesters: tile flash, tile restore, score banner and screen clear. Each requester posts one filled rectangle (origin, size, colour). The block arbitrates round-robin, then scans the granted rectangle one pixel per clock onto `vga_x`/`vga_y`/`colour`/`plot`. It sits between the game controllers and `vga_adapter` (160x120, 3-bit colour) and replaces per-requester plot muxing.

## Interface
Parameters:
- `NREQ`, 3: number of requesters.
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.
- `D_W`, 8: width/height field width.

Ports:
- `clock`  in  1  system clock (`CLOCK_50`).
- `resetn`  in  1  synchronous, active-low reset.
- `req`  in  NREQ  per-requester draw request.
- `req_x`  in  NREQ*X_W  rectangle left edge; requester i uses slice i.
- `req_y`  in  NREQ*Y_W  rectangle top edge.
- `req_w`  in  NREQ*D_W  width in pixels; 0 is legal.
- `req_h`  in  NREQ*D_W  height in pixels; 0 is legal.
- `req_colour`  in  NREQ*3  fill colour.
- `grant`  out  NREQ  one-hot; high while that requester's rectangle is being drawn.
- `done`  out  NREQ  one-cycle pulse when that requester's rectangle completes.
- `busy`  out  1  high in any state other than IDLE.
- `vga_x`  out  X_W  pixel x to `vga_adapter`.
- `vga_y`  out  Y_W  pixel y to `vga_adapter`.
- `colour`  out  3  pixel colour to `vga_adapter`.
- `plot`  out  1  write enable to `vga_adapter`.

## Operation
- FSM has three states: IDLE, DRAW, DONE.
- IDLE:
  - If any `req` bit is high, pick the winner `g` round-robin, starting the search at pointer `ptr`.
  - Latch `req_x/y/w/h/colour` slice g, clear `cx`/`cy`, set `grant[g]`.
  - If w==0 or h==0, go to DONE; otherwise go to DRAW.
  - If no `req` bit is high, stay in IDLE.
- DRAW:
  - Current pixel is (x0+cx, y0+cy), colour c0.
  - Each cycle `cx` increments; when `cx==w-1`, `cx` wraps to 0 and `cy` increments.
  - When `cx==w-1` and `cy==h-1`, go to DONE.
- DONE:
  - `grant` clears and `done[g]` pulses.
  - `ptr` becomes (g+1) mod NREQ.
  - Go to IDLE.
- Handshake:
  - A requester holds `req` and its fields stable until it sees `grant`.
  - Fields are sampled only at the grant edge; later changes have no effect.
  - `req` may drop any time after grant.
  - `req` still high after `done` counts as a new request, served in round-robin order.
  - `req` that drops while still in IDLE is never served.
- Arithmetic:
  - x0+cx is computed at X_W+1 bits and y0+cy at Y_W+1 bits.
  - `plot` = (state==DRAW) && x<160 && y<120.
  - Clipped pixels still take their cycle, with `plot` low.
- `vga_x`/`vga_y` carry the low X_W/Y_W bits of the sums.
- `vga_x`, `vga_y`, `colour` and `plot` are driven only from registered state; there is no combinational path from `req*` inputs.
- Reset while drawing returns to IDLE with no `done` pulse and `ptr`=0.

## Timing
- Reset values: `grant`=0, `done`=0, `busy`=0, `vga_x`=0, `vga_y`=0, `colour`=0, `plot`=0, `ptr`=0.
- If `req` is seen at edge k:
  - `grant` and the first pixel (`plot` high) appear in cycle k+1.
  - Pixel n (0-based, raster order) appears in cycle k+1+n.
  - `done` is high in cycle k+1+w*h.
  - IDLE is re-entered at edge k+2+w*h.
- Total cost is w*h+2 cycles per rectangle, including arbitration.
- A zero-area rectangle gives `grant` in cycle k+1 and `done` in cycle k+2.
- `grant` and `done` are never high together.
- `busy` = !IDLE.
- Back-to-back service: the next grant comes at the earliest one cycle after `done`.

## Structure
- Shared package `draw_pkg` holds:
  - `SCREEN_W`=160 and `SCREEN_H`=120.
  - Colour constants (BLACK=3'b000 … WHITE=3'b111).
  - FSM state encoding.
- Sub-module `rr_arbiter`: combinational one-hot pick from `req` and `ptr`, plus a valid flag.
- Pixel counters, latches and FSM live in the top-level block.

## Test plan
- Single request: req0 with x=10, y=20, w=3, h=2, colour=3'b100.
  - Expect exactly 6 plot cycles: (10,20) (11,20) (12,20) (10,21) (11,21) (12,21).
  - Expect `done[0]` in cycle 7 after the grant edge.
- Fairness: req0, req1 and req2 all held high, each 1x1.
  - Grants go 0,1,2,0,… in that order.
  - No requester is granted twice while another is waiting.
- Zero size: req1 with w=0, h=5.
  - `plot` never goes high.
  - `done[1]` comes 2 cycles after the request edge.
- Clipping: x=158, y=119, w=4, h=2.
  - 8 DRAW cycles; `plot` is high only for (158,119) and (159,119).
- Field change after grant: change req_x from 10 to 50 in the cycle after grant.
  - All pixels still use x=10.
- Reset mid-draw: w=h=10, assert `resetn`=0 at pixel 37.
  - Next cycle all outputs are 0 and no `done` pulse occurs.
  - A subsequent req2 is served normally.
